uart_rx_checker: RTL and testbench
==================================

// Module: uart_rx_checker
// PURPOSE
//  Parametrised UART receiver plus expected-byte checker for caravel/microwatt DV and on-chip self-test.
//  Samples a serial line, deframes configurable NxM frames with optional parity, and reports framing/parity errors.
//  Compares each received word against a queue of expected words; supersedes fixed-baud, single-byte, 8N1-only checkers.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per bit (50 MHz / 115200); legal >= 4
//  DATA_BITS     8    data bits per frame, 5..9, LSB first
//  PARITY        0    0 none, 1 odd, 2 even
//  STOP_BITS     1    1 or 2
//  EXP_DEPTH     4    expected-word FIFO depth, power of 2, >= 2
// PORTS
//  clock        in   1          system clock
//  reset        in   1          synchronous, active-high reset
//  rx           in   1          async serial input, idle high
//  exp_data     in   DATA_BITS  expected word to enqueue
//  exp_valid    in   1          enqueue request
//  exp_ready    out  1          FIFO not full
//  data         out  DATA_BITS  last received word
//  data_valid   out  1          1-cycle pulse: frame complete
//  frame_err    out  1          valid with data_valid: a stop bit sampled 0
//  parity_err   out  1          valid with data_valid: parity mismatch (0 if PARITY==0)
//  match        out  1          1-cycle pulse: word == head of FIFO, no errors
//  mismatch     out  1          1-cycle pulse: FIFO non-empty and (word != head or any error)
//  match_count  out  16         saturating count of match pulses
//  err_count    out  16         saturating count of mismatch pulses plus frames received with FIFO empty
//  busy         out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset: sync regs = 1, FSM IDLE, all pulses/flags 0, data 0, counts 0, FIFO empty (exp_ready=1).
//  rx passes a 2-flop synchroniser; every sample below uses the synchronised value rs.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; one bit counter, one cycle counter.
//   IDLE: rs==0 -> START, cnt=0.
//   START: at cnt==CLKS_PER_BIT/2-1 (integer divide) sample: 0 -> DATA, cnt=0; 1 -> glitch, back to IDLE with no output.
//   DATA: every CLKS_PER_BIT cycles sample; shift in LSB first; after DATA_BITS samples -> PARITY (if PARITY!=0) else STOP.
//   PARITY: sample after CLKS_PER_BIT; parity_err = (XOR of data ^ bit) != (PARITY==1).
//   STOP: sample STOP_BITS times, CLKS_PER_BIT apart; any 0 sets frame_err.
//    On the final stop sample's cycle+1: data, flags updated; data_valid=1 for one cycle; FSM -> IDLE.
//  Data/flags hold until the next data_valid. Return to IDLE at mid-stop-bit is intended; a new frame needs rs==0.
//  Frame latency: rx start edge -> data_valid = 2 + CLKS_PER_BIT/2 + CLKS_PER_BIT*(DATA_BITS+(PARITY!=0)+STOP_BITS-1) + 1 cycles (+-1 edge alignment).
//  Break (rx held 0): frame completes with frame_err=1; FSM waits in IDLE for rs high-then-low (no re-trigger while low).
//  FIFO: push when exp_valid && exp_ready; exp_ready = count != EXP_DEPTH.
//   Compare/pop in the data_valid cycle, same cycle as flag update; match/mismatch coincide with data_valid.
//   FIFO empty at data_valid: no pop, no match/mismatch, err_count += 1 (unexpected word).
//   Simultaneous push+pop: both occur; when full, pop frees no space until next cycle (exp_ready computed from registered count).
//   Push to empty FIFO in the data_valid cycle is not seen by that compare.
//  Counters saturate at 16'hFFFF; no wrap.
//  Reset mid-frame: FSM aborts to IDLE, no data_valid, FIFO flushed, counts cleared, on the next edge.
//  Pointer wrap: read/write pointers log2(EXP_DEPTH) bits wide, modulo EXP_DEPTH; count is log2(EXP_DEPTH)+1 bits.
// TESTING
//  1 8N1 @CLKS_PER_BIT=434: push 0x37, send 0x37 -> data=0x37, data_valid, match, match_count=1, err_count=0.
//  2 push 0x37, send 0x38 -> mismatch, err_count=1, FIFO empty; then send 0x41 with FIFO empty -> no match/mismatch, err_count=2.
//  3 PARITY=2: send 0x55 with parity bit 1 -> parity_err=1, mismatch; correct parity 0 -> match.
//  4 stop bit driven 0 -> frame_err=1, mismatch; rx low pulse of CLKS_PER_BIT/4 -> no data_valid, busy returns to 0.
//  5 EXP_DEPTH=4: push 5 words back-to-back -> exp_ready low after 4th, 5th not stored; 4 matching frames drain FIFO in order.
//  6 reset asserted mid-DATA of frame 2 -> no data_valid, counts 0, exp_ready=1; next clean frame (FIFO empty) -> err_count=1.

Source files
------------

// File: rtl/uart_rx_checker.sv
// uart_rx_checker: UART deframer with parity/stop checks and an expected-word FIFO comparator
module uart_rx_checker #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int EXP_DEPTH    = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_rx,
    input  logic [DATA_BITS-1:0] i_exp_data,
    input  logic                 i_exp_valid,
    output logic                 o_exp_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_data_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_match,
    output logic                 o_mismatch,
    output logic [15:0]          o_match_count,
    output logic [15:0]          o_err_count,
    output logic                 o_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(EXP_DEPTH);
    localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    DLAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    SLAST = 4'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL  = (AW + 1)'(EXP_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 r_state, w_next;
    logic [1:0]             r_sync;
    logic [CW-1:0]          r_cnt;
    logic [3:0]             r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_perr, r_ferr, r_armed;
    logic [DATA_BITS-1:0]   r_mem [EXP_DEPTH];
    logic [AW-1:0]          r_wp, r_rp;
    logic [AW:0]            r_fcnt;
    logic w_rs, w_tick, w_half, w_done, w_fe, w_hit, w_nonempty, w_match, w_mismatch, w_push, w_pop;

    assign w_rs        = r_sync[1];
    assign w_tick      = r_cnt == LAST;
    assign w_half      = r_cnt == HALF;
    assign w_done      = r_state == S_STOP && w_tick && r_bit == SLAST;
    assign w_fe        = r_ferr | ~w_rs;
    assign w_nonempty  = r_fcnt != '0;
    assign w_hit       = !w_fe && !r_perr && r_shift == r_mem[r_rp];
    assign w_match     = w_done && w_nonempty && w_hit;
    assign w_mismatch  = w_done && w_nonempty && !w_hit;
    assign w_push      = i_exp_valid && o_exp_ready;
    assign w_pop       = w_done && w_nonempty;
    assign o_exp_ready = r_fcnt != FULL;
    assign o_busy      = r_state != S_IDLE;

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state: a new frame starts only after the line has been seen idle (re-armed)
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!w_rs && r_armed) w_next = S_START;
            S_START:  if (w_half) w_next = w_rs ? S_IDLE : S_DATA;
            S_DATA:   if (w_tick && r_bit == DLAST) w_next = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_tick) w_next = S_STOP;
            S_STOP:   if (w_tick && r_bit == SLAST) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Synchroniser, bit timing, shift register, error flags, outputs and counters
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync        <= 2'b11;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            r_perr        <= 1'b0;
            r_ferr        <= 1'b0;
            r_armed       <= 1'b0;
            o_data        <= '0;
            o_data_valid  <= 1'b0;
            o_frame_err   <= 1'b0;
            o_parity_err  <= 1'b0;
            o_match       <= 1'b0;
            o_mismatch    <= 1'b0;
            o_match_count <= '0;
            o_err_count   <= '0;
            r_wp          <= '0;
            r_rp          <= '0;
            r_fcnt        <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_rx};
            r_cnt   <= (r_state == S_IDLE || r_state != w_next || w_tick) ? '0 : r_cnt + 1'b1;
            r_bit   <= (r_state != w_next) ? '0 : (w_tick && (r_state == S_DATA || r_state == S_STOP)) ? r_bit + 1'b1 : r_bit;
            r_shift <= (r_state == S_DATA && w_tick) ? {w_rs, r_shift[DATA_BITS-1:1]} : r_shift;
            r_perr  <= (r_state == S_START) ? 1'b0 : (r_state == S_PARITY && w_tick) ? (PARITY != 0) && ((^r_shift ^ w_rs) != (PARITY == 1)) : r_perr;
            r_ferr  <= (r_state == S_START) ? 1'b0 : (r_state == S_STOP && w_tick && !w_rs) ? 1'b1 : r_ferr;
            r_armed <= w_done ? 1'b0 : (r_state == S_IDLE && w_rs) ? 1'b1 : r_armed;
            o_data_valid <= w_done;
            o_match      <= w_match;
            o_mismatch   <= w_mismatch;
            if (w_done) begin
                o_data       <= r_shift;
                o_frame_err  <= w_fe;
                o_parity_err <= r_perr;
            end
            o_match_count <= o_match_count + 16'(w_match && o_match_count != 16'hFFFF);
            o_err_count   <= o_err_count + 16'(w_done && !w_match && o_err_count != 16'hFFFF);
            r_wp   <= r_wp + AW'(w_push);
            r_rp   <= r_rp + AW'(w_pop);
            r_fcnt <= r_fcnt + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
        end
    end

    // Expected-word storage
    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wp] <= i_exp_data;
    end
endmodule

// File: tb/tb_uart_rx_checker.sv
// tb_uart_rx_checker: directed table-driven bench for uart_rx_checker
module tb_uart_rx_checker;
    localparam int CPB  = 434;
    localparam int CPB2 = 16;

    logic        clk = 0, reset = 1;
    logic        rx = 1, rx2 = 1;
    logic [7:0]  exp_d = 0, exp_d2 = 0;
    logic        exp_v = 0, exp_v2 = 0;
    logic        rdy, dv, fe, pe, m, mm, busy;
    logic        rdy2, dv2, fe2, pe2, m2, mm2, busy2;
    logic [7:0]  data, data2;
    logic [15:0] mc, ec, mc2, ec2;

    int checks = 0, errors = 0;
    int dv_cnt = 0, dv_cnt2 = 0;
    logic [7:0] s_data, s_data2;
    logic s_m, s_mm, s_fe, s_m2, s_mm2, s_pe2;

    uart_rx_checker u_dut (
        .i_clock(clk), .i_reset(reset), .i_rx(rx), .i_exp_data(exp_d), .i_exp_valid(exp_v),
        .o_exp_ready(rdy), .o_data(data), .o_data_valid(dv), .o_frame_err(fe), .o_parity_err(pe),
        .o_match(m), .o_mismatch(mm), .o_match_count(mc), .o_err_count(ec), .o_busy(busy)
    );

    uart_rx_checker #(.CLKS_PER_BIT(CPB2), .PARITY(2), .STOP_BITS(2)) u_par (
        .i_clock(clk), .i_reset(reset), .i_rx(rx2), .i_exp_data(exp_d2), .i_exp_valid(exp_v2),
        .o_exp_ready(rdy2), .o_data(data2), .o_data_valid(dv2), .o_frame_err(fe2), .o_parity_err(pe2),
        .o_match(m2), .o_mismatch(mm2), .o_match_count(mc2), .o_err_count(ec2), .o_busy(busy2)
    );

    always #5 clk = ~clk;

    // Snapshot each data_valid pulse shortly after the edge
    always @(posedge clk) begin
        #1;
        if (dv) begin
            dv_cnt++;
            s_data = data; s_m = m; s_mm = mm; s_fe = fe;
        end
        if (dv2) begin
            dv_cnt2++;
            s_data2 = data2; s_m2 = m2; s_mm2 = mm2; s_pe2 = pe2;
        end
    end

    typedef struct {
        logic       push;
        logic [7:0] pv;
        logic [7:0] sd;
        logic       sb;
        logic [7:0] ed;
        logic       em, emm, efe;
        int         emc, eec;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rx = v; else rx2 = v;
    endtask

    task automatic push(input int sel, input logic [7:0] v);
        @(negedge clk);
        if (sel == 0) begin exp_v = 1; exp_d = v; end
        else begin exp_v2 = 1; exp_d2 = v; end
        @(negedge clk);
        exp_v = 0; exp_v2 = 0;
    endtask

    task automatic send(input int sel, input logic [7:0] d, input int cpb, input int par, input logic pb,
                        input int nstop, input logic sv);
        @(negedge clk);
        set_line(sel, 0);
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, d[i]);
            repeat (cpb) @(negedge clk);
        end
        if (par != 0) begin
            set_line(sel, pb);
            repeat (cpb) @(negedge clk);
        end
        set_line(sel, sv);
        repeat (cpb * nstop) @(negedge clk);
        set_line(sel, 1);
        repeat (2 * cpb) @(negedge clk);
    endtask

    initial begin
        int base;
        vt[0] = '{1, 8'h37, 8'h37, 1, 8'h37, 1, 0, 0, 1, 0};
        vt[1] = '{1, 8'h37, 8'h38, 1, 8'h38, 0, 1, 0, 1, 1};
        vt[2] = '{0, 8'h00, 8'h41, 1, 8'h41, 0, 0, 0, 1, 2};
        vt[3] = '{1, 8'hA5, 8'hA5, 0, 8'hA5, 0, 1, 1, 1, 3};
        vt[4] = '{1, 8'h00, 8'h00, 1, 8'h00, 1, 0, 0, 2, 3};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", rdy, 1);
        chk("rst_data", data, 0);
        chk("rst_dv", dv, 0);
        chk("rst_mc", mc, 0);
        chk("rst_ec", ec, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            if (vt[i].push) push(0, vt[i].pv);
            base = dv_cnt;
            send(0, vt[i].sd, CPB, 0, 0, 1, vt[i].sb);
            chk($sformatf("v%0d_dvcnt", i), dv_cnt - base, 1);
            chk($sformatf("v%0d_data", i), s_data, vt[i].ed);
            chk($sformatf("v%0d_match", i), s_m, vt[i].em);
            chk($sformatf("v%0d_mismatch", i), s_mm, vt[i].emm);
            chk($sformatf("v%0d_frame_err", i), s_fe, vt[i].efe);
            chk($sformatf("v%0d_mc", i), mc, vt[i].emc);
            chk($sformatf("v%0d_ec", i), ec, vt[i].eec);
        end

        base = dv_cnt;
        @(negedge clk);
        rx = 0;
        repeat (100) @(negedge clk);
        chk("glitch_busy_mid", busy, 1);
        repeat (CPB / 4 - 100) @(negedge clk);
        rx = 1;
        repeat (2 * CPB) @(negedge clk);
        chk("glitch_no_dv", dv_cnt - base, 0);
        chk("glitch_busy_end", busy, 0);

        @(negedge clk);
        exp_v = 1; exp_d = 8'h11;
        @(negedge clk); exp_d = 8'h22;
        @(negedge clk); exp_d = 8'h33;
        @(negedge clk); exp_d = 8'h44;
        @(negedge clk);
        chk("full_ready", rdy, 0);
        exp_d = 8'h55;
        @(negedge clk);
        exp_v = 0;
        chk("full_ready_hold", rdy, 0);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] w;
            w = 8'(8'h11 * (i + 1));
            send(0, w, CPB, 0, 0, 1, 1);
            chk($sformatf("drain%0d_data", i), s_data, w);
            chk($sformatf("drain%0d_match", i), s_m, 1);
        end
        chk("drain_ready", rdy, 1);
        chk("drain_mc", mc, 6);
        base = dv_cnt;
        send(0, 8'h55, CPB, 0, 0, 1, 1);
        chk("fifth_dv", dv_cnt - base, 1);
        chk("fifth_nomatch", {s_m, s_mm}, 0);
        chk("fifth_ec", ec, 4);

        push(0, 8'h66);
        base = dv_cnt;
        @(negedge clk);
        rx = 0;
        repeat (CPB) @(negedge clk);
        rx = 1;
        repeat (3 * CPB) @(negedge clk);
        chk("midrst_busy", busy, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        repeat (10 * CPB) @(negedge clk);
        chk("midrst_no_dv", dv_cnt - base, 0);
        chk("midrst_mc", mc, 0);
        chk("midrst_ec", ec, 0);
        chk("midrst_ready", rdy, 1);
        chk("midrst_busy_end", busy, 0);
        base = dv_cnt;
        send(0, 8'h66, CPB, 0, 0, 1, 1);
        chk("post_dv", dv_cnt - base, 1);
        chk("post_nomatch", {s_m, s_mm}, 0);
        chk("post_ec", ec, 1);

        push(1, 8'h55);
        base = dv_cnt2;
        send(1, 8'h55, CPB2, 2, 1, 2, 1);
        chk("par_bad_dv", dv_cnt2 - base, 1);
        chk("par_bad_pe", s_pe2, 1);
        chk("par_bad_mm", s_mm2, 1);
        push(1, 8'h55);
        send(1, 8'h55, CPB2, 2, 0, 2, 1);
        chk("par_ok_pe", s_pe2, 0);
        chk("par_ok_match", s_m2, 1);
        chk("par_ok_data", s_data2, 8'h55);
        chk("par_mc", mc2, 1);
        chk("par_ec", ec2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
